// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: resolves execute-stage control flow against the
// prediction that travelled with it, trains a 2-bit branch history table and
// issues a one-cycle flush plus a held valid/ready PC redirect on mispredicts.
module branch_redirect_ctrl #(
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [4:0]       ex_branchOp,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    output logic             ex_stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_flush;
    logic [31:0]       r_redirect_pc;
    logic [CNT_W-1:0]  r_mispredict_cnt;
    logic [1:0]        r_bht [BHT_ENTRIES];
    logic [1:0]        w_bht_d [BHT_ENTRIES];

    logic              w_is_jump;
    logic              w_is_cond;
    logic              w_is_ctrl;
    logic              w_resolve;
    logic              w_mispredict;
    logic              w_bht_we;
    logic [31:0]       w_corrected_pc;
    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [1:0]        w_bht_cur;
    logic [1:0]        w_bht_upd;
    logic              w_unused;

    // Opcode decode: bit 4 marks jumps, bit 3 (without bit 4) marks conditionals.
    assign w_is_jump = ex_branchOp[4];
    assign w_is_cond = ~ex_branchOp[4] & ex_branchOp[3];
    assign w_is_ctrl = w_is_jump | w_is_cond;

    // Resolution is only accepted while no redirect is outstanding.
    assign w_resolve      = ex_valid & w_is_ctrl & (r_state == S_IDLE);
    assign w_mispredict   = w_resolve & (ex_taken != ex_pred_taken);
    assign w_bht_we       = w_resolve & w_is_cond;
    assign w_corrected_pc = ex_taken ? ex_target : ex_pc + 32'd4;

    // Word-aligned PCs: drop the two byte-offset bits before indexing.
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];

    // Lookup reads the registered table, so a same-cycle update is not visible.
    assign if_pred_taken = r_bht[w_if_idx][1];

    // Saturating 2-bit counter step for the entry being trained.
    assign w_bht_cur = r_bht[w_ex_idx];
    always_comb begin
        w_bht_upd = w_bht_cur;
        if (ex_taken) begin
            if (w_bht_cur != 2'b11) w_bht_upd = w_bht_cur + 2'b01;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_upd = w_bht_cur - 2'b01;
        end
    end

    // Per-entry next value: only the indexed entry changes on a conditional resolve.
    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            assign w_bht_d[gi] = (w_bht_we && (w_ex_idx == IDX_W'(gi))) ? w_bht_upd : r_bht[gi];
        end
    endgenerate

    // BHT storage; every counter resets to weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else begin
            r_bht <= w_bht_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next state and state-decoded outputs (stall and redirect valid).
    always_comb begin
        w_state_next   = r_state;
        ex_stall       = 1'b0;
        redirect_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mispredict) w_state_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                ex_stall       = 1'b1;
                redirect_valid = 1'b1;
                if (redirect_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Flush pulse: only mispredicts raise it, and they cannot occur in REDIRECT,
    // so it lasts exactly the first cycle of each redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_flush <= 1'b0;
        else        r_flush <= w_mispredict;
    end

    // Redirect target captured at the mispredict and held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_redirect_pc <= 32'd0;
        else if (w_mispredict) r_redirect_pc <= w_corrected_pc;
    end

    // Running misprediction count, wrapping at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_mispredict_cnt <= '0;
        else if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
    end

    assign flush          = r_flush;
    assign redirect_pc    = r_redirect_pc;
    assign mispredict_cnt = r_mispredict_cnt;

    // PC byte offsets, PC bits above the index and low opcode bits carry no meaning here.
    assign w_unused = &{1'b0, if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[1:0], ex_branchOp[2:0]};

endmodule
